// File: rtl/btn_step_conditioner_pkg.sv
// Shared types and default 100 MHz timing for the push-button step conditioner.
// Also provides the counter-width helper used by the top.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } btn_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
  localparam int unsigned DEF_HOLD_CYCLES     = 50_000_000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_CYCLES   = 20_000_000;  // 0.2 s

  // Width that holds the largest of the three terminal counts.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_step_conditioner_sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous inputs (button, switches).
// Reset value is a parameter so idle-high inputs can reset to their idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples the pre-edge value; blocking here would collapse the
  // two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_step_conditioner.sv
// Debounces BTNC and turns it into press/release/step strobes in the CLK100MHZ
// domain, with optional hold-to-repeat stepping for the downstream counter.
module btn_step_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic btn_in,
  input  logic repeat_en,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DBC_LAST  = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t REP_LAST  = cnt_t'(REPEAT_CYCLES - 1);

  // Timers shorter than two cycles would allow back-to-back step strobes.
  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_timing
    $error("btn_step_conditioner: DEBOUNCE_CYCLES>=1, HOLD_CYCLES>=2, REPEAT_CYCLES>=2 required");
  end

  logic btn_s;

  sync_2ff #(.RST_VAL(1'b0)) u_sync (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .d     (btn_in),
    .q     (btn_s)
  );

  // Debounce: any cycle where btn_s agrees with the accepted level discards
  // all progress, so only an unbroken run of DEBOUNCE_CYCLES flips it.
  logic deb_level;
  cnt_t dbc;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      dbc       <= '0;
      deb_level <= 1'b0;
    end else if (btn_s == deb_level) begin
      dbc <= '0;
    end else if (dbc == DBC_LAST) begin
      dbc       <= '0;
      deb_level <= ~deb_level;
    end else begin
      dbc <= dbc + 1'b1;
    end
  end

  // btn_level is the registered copy of deb_level, so a mismatch marks the
  // single cycle in which a level change has just been accepted.
  logic deb_rise, deb_fall;
  assign deb_rise =  deb_level & ~btn_level;
  assign deb_fall = ~deb_level &  btn_level;

  btn_state_t state, state_n;
  cnt_t       tmr, tmr_n;
  logic       press_n, release_n, step_n;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    tmr_n     = tmr;
    press_n   = 1'b0;
    release_n = 1'b0;
    step_n    = 1'b0;

    unique case (state)
      IDLE: begin
        tmr_n = '0;
        if (deb_rise) begin
          state_n = PRESSED;
          press_n = 1'b1;
          step_n  = 1'b1;
        end
      end

      PRESSED: begin
        if (deb_fall) begin
          state_n   = IDLE;
          release_n = 1'b1;
          tmr_n     = '0;
        end else if (!repeat_en) begin
          tmr_n = '0;
        end else if (tmr == HOLD_LAST) begin
          state_n = REPEAT;
          step_n  = 1'b1;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end

      REPEAT: begin
        // Release outranks a coincident timer expiry: no step on that cycle.
        if (deb_fall) begin
          state_n   = IDLE;
          release_n = 1'b1;
          tmr_n     = '0;
        end else if (!repeat_en) begin
          state_n = PRESSED;
          tmr_n   = '0;
        end else if (tmr == REP_LAST) begin
          step_n = 1'b1;
          tmr_n  = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        tmr_n   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state         <= IDLE;
      tmr           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      step_pulse    <= 1'b0;
    end else begin
      state         <= state_n;
      tmr           <= tmr_n;
      btn_level     <= deb_level;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      step_pulse    <= step_n;
    end
  end

endmodule
